// File: rtl/stamp_load_sched.sv
// Sequences set/zero time loads into the stamp counter, immediately or on the next PPS falling edge.
// Optional ARMED-wait timeout: define STAMP_LOAD_SCHED_PPS_TIMEOUT_EN.
module stamp_load_sched #(
  parameter int                         TIMESTAMP_WIDTH = 64,
  parameter logic [TIMESTAMP_WIDTH-1:0] LOAD_COMP       = '0,
  parameter logic [31:0]                TIMEOUT_CYCLES  = 32'd234375000
) (
  input  logic                       axi_aclk,
  input  logic                       reset,
  input  logic                       cmd_set,
  input  logic                       cmd_zero,
  input  logic                       cmd_align,
  input  logic                       cmd_cancel,
  input  logic [TIMESTAMP_WIDTH-1:0] cmd_time,
  input  logic                       pps_rx,
  output logic [1:0]                 restart_time,
  output logic [TIMESTAMP_WIDTH-1:0] ntp_timestamp,
  output logic                       busy,
  output logic                       done,
  output logic                       cmd_drop,
  output logic                       timeout,
  output logic [15:0]                load_count
);

  typedef enum logic [1:0] {IDLE, ARMED, LOAD, HOLD} state_t;

  state_t state;
  logic   pps_d1, pps_d2, pps_d3;
  logic   op_zero;
  logic   cmd_req;
  logic   pps_edge;
  logic   wait_expired;

  assign cmd_req  = cmd_set | cmd_zero;
  // Falling edge: the same PPS reference point the counter's drift correction uses.
  assign pps_edge = pps_d3 & ~pps_d2;

`ifdef STAMP_LOAD_SCHED_PPS_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_q;

  assign wait_expired = (wait_cnt == TIMEOUT_CYCLES - 32'd1);
  assign timeout      = timeout_q;

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
      if (cmd_req) timeout_q <= 1'b0;
    end else if (state == ARMED) begin
      wait_cnt <= wait_cnt + 32'd1;
      if (!cmd_cancel && !pps_edge && wait_expired) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wait_expired       = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state         <= IDLE;
      pps_d1        <= 1'b0;
      pps_d2        <= 1'b0;
      pps_d3        <= 1'b0;
      op_zero       <= 1'b0;
      restart_time  <= 2'b00;
      ntp_timestamp <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cmd_drop      <= 1'b0;
      load_count    <= '0;
    end else begin
      pps_d1       <= pps_rx;
      pps_d2       <= pps_d1;
      pps_d3       <= pps_d2;
      restart_time <= 2'b00;
      done         <= 1'b0;
      cmd_drop     <= cmd_req && (state != IDLE);
      // restart_time/load_count are set on the edge entering LOAD so the pulse is visible during LOAD
      case (state)
        IDLE: if (cmd_req) begin
          op_zero <= cmd_zero;
          if (!cmd_zero) ntp_timestamp <= cmd_time + LOAD_COMP;
          busy <= 1'b1;
          if (cmd_align) begin
            state <= ARMED;
          end else begin
            state        <= LOAD;
            restart_time <= cmd_zero ? 2'b10 : 2'b01;
            load_count   <= load_count + 16'd1;
          end
        end
        ARMED: begin
          if (cmd_cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pps_edge) begin
            state        <= LOAD;
            restart_time <= op_zero ? 2'b10 : 2'b01;
            load_count   <= load_count + 16'd1;
          end else if (wait_expired) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          state <= HOLD;
          done  <= 1'b1;
        end
        HOLD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
